// File: rtl/execute_stage.sv
// Single-issue MIPS execute stage: ALU, branch/jump resolution, memory request generation
// and an iterative multiply/divide unit with private HI/LO registers.
module execute_stage #(
  parameter int unsigned data_width = 32,
  parameter int unsigned mdu_cycles = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable_execute,
  input  logic [data_width-1:0] pc,
  input  logic [5:0]            opcode,
  input  logic [5:0]            func,
  input  logic [4:0]            rt,
  input  logic [4:0]            rd,
  input  logic [4:0]            sa,
  input  logic [25:0]           imm,
  input  logic [data_width-1:0] rs_data,
  input  logic [data_width-1:0] rt_data,
  output logic                  stall,
  output logic                  valid_out,
  output logic [data_width-1:0] result_out,
  output logic [4:0]            dest_out,
  output logic                  write_en_out,
  output logic                  mem_read_out,
  output logic                  mem_write_out,
  output logic [data_width-1:0] store_data_out,
  output logic                  branch_taken_out,
  output logic [data_width-1:0] branch_target_out
);

  localparam int unsigned W    = data_width;
  localparam int unsigned CntW = $clog2(mdu_cycles);

  localparam logic [5:0] OpSpecial = 6'h00, OpJ = 6'h02, OpJal = 6'h03, OpBeq = 6'h04;
  localparam logic [5:0] OpBne = 6'h05, OpBlez = 6'h06, OpBgtz = 6'h07, OpAddi = 6'h08;
  localparam logic [5:0] OpAddiu = 6'h09, OpSlti = 6'h0a, OpSltiu = 6'h0b, OpAndi = 6'h0c;
  localparam logic [5:0] OpOri = 6'h0d, OpXori = 6'h0e, OpLui = 6'h0f, OpLw = 6'h23;
  localparam logic [5:0] OpSw = 6'h2b;

  localparam logic [5:0] FnSll = 6'h00, FnSrl = 6'h02, FnSra = 6'h03, FnSllv = 6'h04;
  localparam logic [5:0] FnSrlv = 6'h06, FnSrav = 6'h07, FnJr = 6'h08, FnMfhi = 6'h10;
  localparam logic [5:0] FnMflo = 6'h12, FnMult = 6'h18, FnMultu = 6'h19, FnDiv = 6'h1a;
  localparam logic [5:0] FnDivu = 6'h1b, FnAdd = 6'h20, FnAddu = 6'h21, FnSub = 6'h22;
  localparam logic [5:0] FnSubu = 6'h23, FnAnd = 6'h24, FnOr = 6'h25, FnXor = 6'h26;
  localparam logic [5:0] FnNor = 6'h27, FnSlt = 6'h2a, FnSltu = 6'h2b;

  typedef enum logic [1:0] {StIdle, StMul, StDiv} mdu_state_e;

  mdu_state_e        state_q;
  logic [CntW-1:0]   count_q;
  logic [2*W-1:0]    acc_q;
  logic [W-1:0]      opb_q, dividend_q, hi_q, lo_q;
  logic              neg_q, neg_rem_q, div_zero_q;

  logic              accept, mul_start, div_start, mdu_signed, last_iter;
  logic [W-1:0]      sext, zext, pc_plus4, a_mag, b_mag;
  logic [W-1:0]      res_d, store_d, tgt_d;
  logic [4:0]        dest_d;
  logic              we_d, mr_d, mw_d, bt_d;
  logic [W:0]        mul_sum, rem_sh, diff;
  logic [2*W-1:0]    mul_step, div_step;

  assign stall     = (state_q != StIdle);
  assign accept    = enable_execute & ~stall;
  assign sext      = {{(W-16){imm[15]}}, imm[15:0]};
  assign zext      = {{(W-16){1'b0}}, imm[15:0]};
  assign pc_plus4  = pc + W'(4);
  assign last_iter = (count_q == CntW'(mdu_cycles - 1));

  always_comb begin
    res_d      = '0;
    store_d    = '0;
    tgt_d      = '0;
    dest_d     = '0;
    we_d       = 1'b0;
    mr_d       = 1'b0;
    mw_d       = 1'b0;
    bt_d       = 1'b0;
    mul_start  = 1'b0;
    div_start  = 1'b0;
    mdu_signed = 1'b0;
    if (accept) begin
      dest_d = rt;
      case (opcode)
        OpSpecial: begin
          dest_d = rd;
          we_d   = 1'b1;
          case (func)
            FnSll:         res_d = rt_data << sa;
            FnSrl:         res_d = rt_data >> sa;
            FnSra:         res_d = $signed(rt_data) >>> sa;
            FnSllv:        res_d = rt_data << rs_data[4:0];
            FnSrlv:        res_d = rt_data >> rs_data[4:0];
            FnSrav:        res_d = $signed(rt_data) >>> rs_data[4:0];
            FnMfhi:        res_d = hi_q;
            FnMflo:        res_d = lo_q;
            FnAdd, FnAddu: res_d = rs_data + rt_data;
            FnSub, FnSubu: res_d = rs_data - rt_data;
            FnAnd:         res_d = rs_data & rt_data;
            FnOr:          res_d = rs_data | rt_data;
            FnXor:         res_d = rs_data ^ rt_data;
            FnNor:         res_d = ~(rs_data | rt_data);
            FnSlt:         res_d = {{(W-1){1'b0}}, $signed(rs_data) < $signed(rt_data)};
            FnSltu:        res_d = {{(W-1){1'b0}}, rs_data < rt_data};
            FnJr: begin
              we_d  = 1'b0;
              bt_d  = 1'b1;
              tgt_d = rs_data;
            end
            FnMult, FnMultu: begin
              we_d       = 1'b0;
              mul_start  = 1'b1;
              mdu_signed = (func == FnMult);
            end
            FnDiv, FnDivu: begin
              we_d       = 1'b0;
              div_start  = 1'b1;
              mdu_signed = (func == FnDiv);
            end
            default:       we_d = 1'b0;
          endcase
        end
        OpJ, OpJal: begin
          bt_d  = 1'b1;
          tgt_d = {pc_plus4[W-1:W-4], imm, 2'b00};
          if (opcode == OpJal) begin
            we_d   = 1'b1;
            dest_d = 5'd31;
            res_d  = pc + W'(8);
          end
        end
        OpBeq, OpBne, OpBlez, OpBgtz: begin
          tgt_d = pc_plus4 + (sext << 2);
          case (opcode)
            OpBeq:   bt_d = (rs_data == rt_data);
            OpBne:   bt_d = (rs_data != rt_data);
            OpBlez:  bt_d = rs_data[W-1] | (rs_data == '0);
            default: bt_d = ~rs_data[W-1] & (rs_data != '0);
          endcase
        end
        OpAddi, OpAddiu: begin res_d = rs_data + sext; we_d = 1'b1; end
        OpSlti:  begin res_d = {{(W-1){1'b0}}, $signed(rs_data) < $signed(sext)}; we_d = 1'b1; end
        OpSltiu: begin res_d = {{(W-1){1'b0}}, rs_data < sext}; we_d = 1'b1; end
        OpAndi:  begin res_d = rs_data & zext; we_d = 1'b1; end
        OpOri:   begin res_d = rs_data | zext; we_d = 1'b1; end
        OpXori:  begin res_d = rs_data ^ zext; we_d = 1'b1; end
        OpLui:   begin res_d = {imm[15:0], {(W-16){1'b0}}}; we_d = 1'b1; end
        // Loads leave write-back to the memory stage.
        OpLw:    begin res_d = rs_data + sext; mr_d = 1'b1; end
        OpSw: begin
          res_d   = rs_data + sext;
          mw_d    = 1'b1;
          store_d = rt_data;
        end
        default: ;
      endcase
    end
  end

  // Operand magnitudes and one iteration of shift-add multiply / restoring divide.
  always_comb begin
    a_mag    = (mdu_signed & rs_data[W-1]) ? -rs_data : rs_data;
    b_mag    = (mdu_signed & rt_data[W-1]) ? -rt_data : rt_data;
    mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_step = {mul_sum, acc_q[W-1:1]};
    rem_sh   = acc_q[2*W-1:W-1];
    diff     = rem_sh - {1'b0, opb_q};
    div_step = diff[W] ? {rem_sh[W-1:0], acc_q[W-2:0], 1'b0}
                       : {diff[W-1:0], acc_q[W-2:0], 1'b1};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      count_q    <= '0;
      acc_q      <= '0;
      opb_q      <= '0;
      dividend_q <= '0;
      neg_q      <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          count_q <= '0;
          if (mul_start) begin
            state_q <= StMul;
            acc_q   <= {{W{1'b0}}, b_mag};
            opb_q   <= a_mag;
            neg_q   <= mdu_signed & (rs_data[W-1] ^ rt_data[W-1]);
          end else if (div_start) begin
            state_q    <= StDiv;
            acc_q      <= {{W{1'b0}}, a_mag};
            opb_q      <= b_mag;
            neg_q      <= mdu_signed & (rs_data[W-1] ^ rt_data[W-1]);
            neg_rem_q  <= mdu_signed & rs_data[W-1];
            div_zero_q <= (rt_data == '0);
            dividend_q <= rs_data;
          end
        end
        StMul: begin
          acc_q   <= mul_step;
          count_q <= count_q + 1'b1;
          if (last_iter) begin
            state_q      <= StIdle;
            {hi_q, lo_q} <= neg_q ? -mul_step : mul_step;
          end
        end
        StDiv: begin
          acc_q   <= div_step;
          count_q <= count_q + 1'b1;
          if (last_iter) begin
            state_q <= StIdle;
            if (div_zero_q) begin
              lo_q <= '1;
              hi_q <= dividend_q;
            end else begin
              lo_q <= neg_q ? -div_step[W-1:0] : div_step[W-1:0];
              hi_q <= neg_rem_q ? -div_step[2*W-1:W] : div_step[2*W-1:W];
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_out         <= 1'b0;
      result_out        <= '0;
      dest_out          <= '0;
      write_en_out      <= 1'b0;
      mem_read_out      <= 1'b0;
      mem_write_out     <= 1'b0;
      store_data_out    <= '0;
      branch_taken_out  <= 1'b0;
      branch_target_out <= '0;
    end else begin
      valid_out         <= accept;
      result_out        <= res_d;
      dest_out          <= dest_d;
      write_en_out      <= we_d;
      mem_read_out      <= mr_d;
      mem_write_out     <= mw_d;
      store_data_out    <= store_d;
      branch_taken_out  <= bt_d;
      branch_target_out <= tgt_d;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Randomised scoreboard bench for execute_stage: a stimulus process queues expected responses
// from an arithmetic reference model; a monitor pops and compares after every clock edge.
module tb_execute_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable_execute;
  logic [31:0] pc;
  logic [5:0]  opcode, func;
  logic [4:0]  rt, rd, sa;
  logic [25:0] imm;
  logic [31:0] rs_data, rt_data;
  logic        stall, valid_out, write_en_out, mem_read_out, mem_write_out, branch_taken_out;
  logic [31:0] result_out, store_data_out, branch_target_out;
  logic [4:0]  dest_out;

  execute_stage #(.data_width(32), .mdu_cycles(32)) dut (
    .clock(clock), .reset(reset), .enable_execute(enable_execute), .pc(pc),
    .opcode(opcode), .func(func), .rt(rt), .rd(rd), .sa(sa), .imm(imm),
    .rs_data(rs_data), .rt_data(rt_data), .stall(stall), .valid_out(valid_out),
    .result_out(result_out), .dest_out(dest_out), .write_en_out(write_en_out),
    .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
    .store_data_out(store_data_out), .branch_taken_out(branch_taken_out),
    .branch_target_out(branch_target_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        valid, stall, we, mr, mw, bt;
    logic        chk_res, chk_dest, chk_tgt;
    logic [31:0] res, tgt, store;
    logic [4:0]  dest;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;

  // Reference model state: architectural HI/LO, pending MDU result and busy cycles left.
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  int          m_busy = 0;

  logic [5:0] r_fn [19] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h10, 6'h12,
                            6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a,
                            6'h2b};
  logic [5:0] mdu_fn [4] = '{6'h18, 6'h19, 6'h1a, 6'h1b};
  logic [5:0] i_op [16] = '{6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09, 6'h0a,
                            6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h23, 6'h2b};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] sx(input logic [25:0] i);
    return {{16{i[15]}}, i[15:0]};
  endfunction

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'($urandom_range(0, 15));
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_stall"}, 32'(stall), 32'h0);
    check({tag, "_valid"}, 32'(valid_out), 32'h0);
    check({tag, "_result"}, result_out, 32'h0);
    check({tag, "_dest"}, 32'(dest_out), 32'h0);
    check({tag, "_we"}, 32'(write_en_out), 32'h0);
    check({tag, "_mr"}, 32'(mem_read_out), 32'h0);
    check({tag, "_mw"}, 32'(mem_write_out), 32'h0);
    check({tag, "_store"}, store_data_out, 32'h0);
    check({tag, "_bt"}, 32'(branch_taken_out), 32'h0);
    check({tag, "_target"}, branch_target_out, 32'h0);
  endtask

  // Drive one cycle of stimulus and queue what the stage must show after the next edge.
  task automatic issue(input logic en, input logic [31:0] ipc, input logic [5:0] op,
                       input logic [5:0] fn, input logic [4:0] irt, input logic [4:0] ird,
                       input logic [4:0] isa, input logic [25:0] iimm,
                       input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [31:0] r, pc4;
    logic        w;
    @(negedge clock);
    enable_execute = en; pc = ipc; opcode = op; func = fn; rt = irt; rd = ird; sa = isa;
    imm = iimm; rs_data = a; rt_data = b;
    e = '{default: '0};
    r = '0;
    w = 1'b0;
    pc4 = ipc + 32'd4;
    if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        m_hi = p_hi;
        m_lo = p_lo;
      end
    end else if (en) begin
      e.valid = 1'b1;
      e.dest  = irt;
      if (op == 6'h00) begin
        e.dest = ird;
        w = 1'b1;
        case (fn)
          6'h00: r = b << isa;
          6'h02: r = b >> isa;
          6'h03: r = $signed(b) >>> isa;
          6'h04: r = b << a[4:0];
          6'h06: r = b >> a[4:0];
          6'h07: r = $signed(b) >>> a[4:0];
          6'h10: r = m_hi;
          6'h12: r = m_lo;
          6'h20, 6'h21: r = a + b;
          6'h22, 6'h23: r = a - b;
          6'h24: r = a & b;
          6'h25: r = a | b;
          6'h26: r = a ^ b;
          6'h27: r = ~(a | b);
          6'h2a: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          6'h2b: r = (a < b) ? 32'd1 : 32'd0;
          6'h08: begin w = 1'b0; e.bt = 1'b1; e.tgt = a; e.chk_tgt = 1'b1; end
          6'h18: begin
            longint pp;
            pp = longint'($signed(a)) * longint'($signed(b));
            {p_hi, p_lo} = pp;
            w = 1'b0; m_busy = 32;
          end
          6'h19: begin {p_hi, p_lo} = {32'h0, a} * {32'h0, b}; w = 1'b0; m_busy = 32; end
          6'h1a: begin
            longint q, rm;
            if (b == 0) begin
              p_lo = '1; p_hi = a;
            end else begin
              q = longint'($signed(a)) / longint'($signed(b));
              rm = longint'($signed(a)) % longint'($signed(b));
              p_lo = q[31:0]; p_hi = rm[31:0];
            end
            w = 1'b0; m_busy = 32;
          end
          6'h1b: begin
            if (b == 0) begin p_lo = '1; p_hi = a; end
            else begin p_lo = a / b; p_hi = a % b; end
            w = 1'b0; m_busy = 32;
          end
          default: w = 1'b0;
        endcase
      end else begin
        case (op)
          6'h02, 6'h03: begin
            e.bt = 1'b1; e.tgt = {pc4[31:28], iimm, 2'b00}; e.chk_tgt = 1'b1;
            if (op == 6'h03) begin w = 1'b1; r = ipc + 32'd8; e.dest = 5'd31; end
          end
          6'h04, 6'h05, 6'h06, 6'h07: begin
            e.tgt = pc4 + (sx(iimm) << 2);
            e.chk_tgt = 1'b1;
            case (op)
              6'h04:   e.bt = (a == b);
              6'h05:   e.bt = (a != b);
              6'h06:   e.bt = ($signed(a) <= 0);
              default: e.bt = ($signed(a) > 0);
            endcase
          end
          6'h08, 6'h09: begin w = 1'b1; r = a + sx(iimm); end
          6'h0a: begin w = 1'b1; r = ($signed(a) < $signed(sx(iimm))) ? 32'd1 : 32'd0; end
          6'h0b: begin w = 1'b1; r = (a < sx(iimm)) ? 32'd1 : 32'd0; end
          6'h0c: begin w = 1'b1; r = a & {16'h0, iimm[15:0]}; end
          6'h0d: begin w = 1'b1; r = a | {16'h0, iimm[15:0]}; end
          6'h0e: begin w = 1'b1; r = a ^ {16'h0, iimm[15:0]}; end
          6'h0f: begin w = 1'b1; r = {iimm[15:0], 16'h0}; end
          6'h23: begin
            e.mr = 1'b1; e.res = a + sx(iimm); e.chk_res = 1'b1; e.chk_dest = 1'b1;
          end
          6'h2b: begin e.mw = 1'b1; e.res = a + sx(iimm); e.chk_res = 1'b1; e.store = b; end
          default: ;
        endcase
      end
      if (w) begin
        e.we = 1'b1; e.res = r; e.chk_res = 1'b1; e.chk_dest = 1'b1;
      end
    end
    e.stall = (m_busy > 0);
    sb_q.push_back(e);
  endtask

  task automatic issue_rand(input logic en);
    logic [5:0]  op, fn;
    logic [31:0] a, b;
    int          k;
    op = 6'h00;
    fn = 6'h00;
    k = $urandom_range(0, 99);
    if (k < 4) op = 6'h3f;
    else if (k < 7) fn = 6'h3f;
    else if (k < 12) fn = mdu_fn[$urandom_range(0, 3)];
    else if (k < 55) fn = r_fn[$urandom_range(0, 18)];
    else op = i_op[$urandom_range(0, 15)];
    a = rand_word();
    b = ($urandom_range(0, 3) == 0) ? a : rand_word();
    issue(en, $urandom & 32'hFFFF_FFFC, op, fn, 5'($urandom), 5'($urandom), 5'($urandom),
          26'($urandom), a, b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      issue(1'b0, 32'h0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 26'h0, 32'h0, 32'h0);
  endtask

  // Monitor: one queued expectation per clock edge, sampled just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("stall", 32'(stall), 32'(e.stall));
        check("valid_out", 32'(valid_out), 32'(e.valid));
        check("write_en_out", 32'(write_en_out), 32'(e.we));
        check("mem_read_out", 32'(mem_read_out), 32'(e.mr));
        check("mem_write_out", 32'(mem_write_out), 32'(e.mw));
        check("branch_taken_out", 32'(branch_taken_out), 32'(e.bt));
        if (e.chk_res) check("result_out", result_out, e.res);
        if (e.chk_dest) check("dest_out", 32'(dest_out), 32'(e.dest));
        if (e.chk_tgt) check("branch_target_out", branch_target_out, e.tgt);
        if (e.mw) check("store_data_out", store_data_out, e.store);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    enable_execute = 1'b0; pc = '0; opcode = '0; func = '0; rt = '0; rd = '0; sa = '0;
    imm = '0; rs_data = '0; rt_data = '0;
    @(negedge clock);
    #1;
    check_zero("reset");
    reset = 1'b0;

    issue(1'b1, 32'h0, 6'h00, 6'h21, 5'd0, 5'd3, 5'd0, 26'h0, 32'h7FFF_FFFF, 32'd1);
    issue(1'b1, 32'h8002_0010, 6'h04, 6'h00, 5'd0, 5'd0, 5'd0, 26'h000_FFFC, 32'd5, 32'd5);
    issue(1'b1, 32'h8002_0010, 6'h04, 6'h00, 5'd0, 5'd0, 5'd0, 26'h000_FFFC, 32'd5, 32'd6);

    issue(1'b1, 32'h0, 6'h00, 6'h18, 5'd0, 5'd0, 5'd0, 26'h0, 32'hFFFF_FFFE, 32'd3);
    for (int i = 0; i < 32; i++) issue_rand($urandom_range(0, 1) == 1);
    issue(1'b1, 32'h0, 6'h00, 6'h12, 5'd0, 5'd4, 5'd0, 26'h0, 32'h0, 32'h0);
    issue(1'b1, 32'h0, 6'h00, 6'h10, 5'd0, 5'd5, 5'd0, 26'h0, 32'h0, 32'h0);

    issue(1'b1, 32'h0, 6'h00, 6'h1a, 5'd0, 5'd0, 5'd0, 26'h0, 32'hFFFF_FFF9, 32'd2);
    idle(32);
    issue(1'b1, 32'h0, 6'h00, 6'h12, 5'd0, 5'd6, 5'd0, 26'h0, 32'h0, 32'h0);
    issue(1'b1, 32'h0, 6'h00, 6'h10, 5'd0, 5'd7, 5'd0, 26'h0, 32'h0, 32'h0);
    issue(1'b1, 32'h0, 6'h00, 6'h1b, 5'd0, 5'd0, 5'd0, 26'h0, 32'h1234, 32'h0);
    idle(32);
    issue(1'b1, 32'h0, 6'h00, 6'h12, 5'd0, 5'd6, 5'd0, 26'h0, 32'h0, 32'h0);
    issue(1'b1, 32'h0, 6'h00, 6'h10, 5'd0, 5'd7, 5'd0, 26'h0, 32'h0, 32'h0);

    issue(1'b1, 32'h8002_0000, 6'h03, 6'h00, 5'd0, 5'd0, 5'd0, 26'h000_8010, 32'h0, 32'h0);
    issue(1'b1, 32'h0, 6'h23, 6'h00, 5'd9, 5'd0, 5'd0, 26'h000_FFFC, 32'h8002_0000, 32'h0);

    for (int i = 0; i < 700; i++) issue_rand($urandom_range(0, 9) != 0);

    // Reset in the middle of a divide: everything clears without a clock edge.
    issue(1'b1, 32'h0, 6'h00, 6'h1a, 5'd0, 5'd0, 5'd0, 26'h0, 32'd1000, 32'd7);
    idle(10);
    @(negedge clock);
    #2;
    reset = 1'b1;
    m_busy = 0; m_hi = '0; m_lo = '0;
    #1;
    check_zero("async_reset");
    @(negedge clock);
    #1;
    reset = 1'b0;
    issue(1'b1, 32'h0, 6'h00, 6'h10, 5'd0, 5'd8, 5'd0, 26'h0, 32'h0, 32'h0);
    issue(1'b1, 32'h0, 6'h00, 6'h12, 5'd0, 5'd8, 5'd0, 26'h0, 32'h0, 32'h0);
    for (int i = 0; i < 100; i++) issue_rand($urandom_range(0, 9) != 0);

    repeat (3) @(negedge clock);
    check("scoreboard_drained", 32'(sb_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
Single-issue MIPS execute stage. It sits directly downstream of decode and consumes decoded fields plus register operands. It produces a registered ALU result, the destination register, branch/jump resolution and memory-access requests for the following memory stage. MULT/MULTU/DIV/DIVU run on an iterative 32-cycle unit with internal HI/LO registers, and the stage stalls upstream while that unit is busy.

Parameters:
data_width, 32, operand/result width (only 32 supported)
mdu_cycles, 32, iterations of the multiply/divide unit

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
enable_execute  input  1  decoded instruction valid this cycle
pc  input  32  address of the instruction
opcode  input  6  opcode field
func  input  6  function field
rt  input  5  rt field
rd  input  5  rd field
sa  input  5  shift amount
imm  input  26  immediate/offset field (low 16 bits for I-type, all 26 bits for J-type)
rs_data  input  32  value of register rs
rt_data  input  32  value of register rt
stall  output  1  high while the multiply/divide unit is busy; upstream holds its inputs
valid_out  output  1  result registers hold an accepted instruction
result_out  output  32  ALU result, effective address, or link address
dest_out  output  5  destination register
write_en_out  output  1  register write-back required
mem_read_out  output  1  LW
mem_write_out  output  1  SW
store_data_out  output  32  rt_data for SW
branch_taken_out  output  1  redirect fetch
branch_target_out  output  32  redirect address

Behaviour:
- Accept: an instruction is accepted on a rising edge when enable_execute=1 and stall=0. While stall=1, inputs are ignored and valid_out=0.
- Latency: all outputs are registered. Results appear one cycle after the accept edge. Without an accept, valid_out=0, write_en_out=0, mem flags=0, branch_taken_out=0.
- Immediates: sext = sign-extend imm[15:0]; zext = zero-extend imm[15:0].
- R-type ops (opcode 0x00, selected by func), with dest=rd:
  - SLL/SRL/SRA by sa; SLLV/SRLV/SRAV by rs_data[4:0].
  - ADD/ADDU/SUB/SUBU wrap modulo 2^32 with no overflow trap.
  - AND, OR, XOR, NOR.
  - SLT signed compare, SLTU unsigned compare; result is 1 or 0.
  - MFHI/MFLO return HI/LO.
  - JR: taken, target=rs_data, no write.
- I-type ops, with dest=rt:
  - ADDI/ADDIU: rs+sext. SLTI (signed) / SLTIU (unsigned) compare against sext.
  - ANDI/ORI/XORI use zext. LUI: result = {imm[15:0], 16'h0}.
- Branches (no write): BEQ, BNE, BLEZ, BGTZ compare rs_data (and rt_data for BEQ/BNE). Target = pc+4+(sext<<2), driven even when not taken.
- Jumps: J and JAL target = {(pc+4)[31:28], imm, 2'b00}. JAL also writes result=pc+8, dest=31.
- Loads/stores: LW/SW compute result = rs+sext. LW: mem_read_out=1, dest=rt, write_en_out=0 (the memory stage writes back). SW: mem_write_out=1, store_data_out=rt_data.
- Unsupported opcode/func: valid_out=1, all other flags 0 (NOP).
- MDU state machine, states IDLE, MUL, DIV:
  - IDLE -> MUL on accept of MULT/MULTU; IDLE -> DIV on accept of DIV/DIVU. The accepting instruction itself produces valid_out=1 with write_en_out=0.
  - stall = (state != IDLE), held for exactly mdu_cycles cycles. HI/LO update on the final iteration edge; state returns to IDLE on that same edge.
  - MUL is shift-add on operand magnitudes, with the sign applied at the end for MULT. HI:LO = 64-bit product.
  - DIV is restoring division on magnitudes. LO = quotient truncated toward zero; HI = remainder with the dividend's sign.
  - Divide by zero: still 32 cycles; LO=0xFFFFFFFF, HI=dividend.
  - MFHI/MFLO accepted after stall drops return the updated values. Back-to-back MDU ops are legal.
- Reset (any time, including mid-MDU): all outputs 0, HI=LO=0, state IDLE, stall=0 immediately. The operation in progress is abandoned.

Test Plan:
- ADDU rs_data=0x7FFFFFFF, rt_data=1, rd=3 -> next cycle: result_out=0x80000000, dest_out=3, write_en_out=1, valid_out=1.
- BEQ pc=0x80020010, rs_data=rt_data=5, imm=0xFFFC -> branch_taken_out=1, branch_target_out=0x80020004, write_en_out=0. Repeat with rt_data=6 -> taken=0.
- MULT rs_data=0xFFFFFFFE, rt_data=3 -> stall=1 for exactly 32 cycles, enable_execute pulses during the stall ignored. Then MFLO -> 0xFFFFFFFA and MFHI -> 0xFFFFFFFF.
- DIV rs_data=0xFFFFFFF9 (-7), rt_data=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU rs_data=0x1234, rt_data=0 -> LO=0xFFFFFFFF, HI=0x1234.
- JAL pc=0x80020000, imm=0x0008010 -> target=0x80020040, result_out=0x80020008, dest_out=31, write_en_out=1. LW rs_data=0x80020000, imm=0xFFFC -> result_out=0x8001FFFC, mem_read_out=1.
- Assert reset at cycle 10 of a DIV -> stall, valid_out and all outputs 0 without waiting for a clock edge. After release, MFHI -> 0.
